// File: rtl/conf_bus_sched.sv
// Config bus master: merges UART parameter writes, a buck soft-start ramp and an
// OCD fault shutdown into at most one registered bus write per cycle.
module conf_bus_sched #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 4,
  parameter logic [ADDR_W-1:0] PW_ADDR   = 4'd1,
  parameter logic [ADDR_W-1:0] BUCK_ADDR = 4'd4,
  parameter logic [ADDR_W-1:0] CLR_ADDR  = 4'd15,
  parameter int unsigned RAMP_DIV  = 5000,
  parameter int unsigned RAMP_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] u_data,
  input  logic [ADDR_W-1:0] u_addr,
  input  logic              u_valid,
  input  logic              ocd_fault,
  output logic [DATA_W-1:0] bus_data,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_en,
  output logic [DATA_W-1:0] buck_cur,
  output logic              lockout,
  output logic              u_drop
);

  localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RAMP_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
  localparam logic [DATA_W:0]   STEP     = (DATA_W + 1)'(RAMP_STEP);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RAMP       = 3'd1,
    ST_FAULT_PW   = 3'd2,
    ST_FAULT_BUCK = 3'd3,
    ST_LOCKOUT    = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic [DATA_W-1:0] buck_tgt;
  logic [DIV_W-1:0]  div;
  logic              ramp_pend;

  logic              fault_wr;
  logic              in_fault;
  logic              drain;
  logic              uart_wr;
  logic              ramp_fire;
  logic              ramp_wr;
  logic              clr_ok;
  logic [DATA_W:0]   step_sum;
  logic [DATA_W-1:0] ramp_val;
  logic              nxt_en;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] nxt_data;
  logic [DATA_W-1:0] cur_next;
  logic [DATA_W-1:0] tgt_next;

  // Fault writes own the bus outright; the buffer only drains when they are not issuing.
  assign fault_wr  = (state == ST_FAULT_PW) || (state == ST_FAULT_BUCK);
  assign in_fault  = fault_wr || (state == ST_LOCKOUT);
  assign drain     = buf_valid && !fault_wr;
  assign uart_wr   = drain && (buf_addr != BUCK_ADDR) && (buf_addr != CLR_ADDR) &&
                     !(in_fault && (buf_addr == PW_ADDR));
  assign clr_ok    = drain && (buf_addr == CLR_ADDR) && (state == ST_LOCKOUT) && !ocd_fault;
  assign ramp_fire = (state == ST_RAMP) && (buck_cur != buck_tgt) &&
                     (ramp_pend || (div == DIV_LAST));
  assign ramp_wr   = ramp_fire && !uart_wr;
  assign step_sum  = {1'b0, buck_cur} + STEP;

  // Next ramp level: saturating step up, immediate drop when above target.
  always_comb begin
    ramp_val = buck_tgt;
    if (buck_cur > buck_tgt) begin
      ramp_val = buck_tgt;
    end else if (step_sum > {1'b0, buck_tgt}) begin
      ramp_val = buck_tgt;
    end else begin
      ramp_val = step_sum[DATA_W-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (ocd_fault) state_next = ST_FAULT_PW;
        else if (buck_cur != buck_tgt) state_next = ST_RAMP;
        else state_next = ST_IDLE;
      end
      ST_RAMP: begin
        if (ocd_fault) state_next = ST_FAULT_PW;
        else if (buck_cur == buck_tgt) state_next = ST_IDLE;
        else state_next = ST_RAMP;
      end
      ST_FAULT_PW:   state_next = ST_FAULT_BUCK;
      ST_FAULT_BUCK: state_next = ST_LOCKOUT;
      ST_LOCKOUT: begin
        if (clr_ok) state_next = ST_IDLE;
        else state_next = ST_LOCKOUT;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus arbitration (fault > UART > ramp) and buck level updates.
  always_comb begin
    nxt_en   = 1'b0;
    nxt_addr = '0;
    nxt_data = '0;
    cur_next = buck_cur;
    tgt_next = buck_tgt;
    case (state)
      ST_FAULT_PW: begin
        nxt_en   = 1'b1;
        nxt_addr = PW_ADDR;
      end
      ST_FAULT_BUCK: begin
        nxt_en   = 1'b1;
        nxt_addr = BUCK_ADDR;
        cur_next = '0;
        tgt_next = '0;
      end
      default: begin
        if (drain && (buf_addr == BUCK_ADDR)) begin
          tgt_next = buf_data;
        end else begin
          tgt_next = buck_tgt;
        end
        if (uart_wr) begin
          nxt_en   = 1'b1;
          nxt_addr = buf_addr;
          nxt_data = buf_data;
        end else if (ramp_wr) begin
          nxt_en   = 1'b1;
          nxt_addr = BUCK_ADDR;
          nxt_data = ramp_val;
          cur_next = ramp_val;
        end else begin
          nxt_en   = 1'b0;
        end
      end
    endcase
  end

  // State, buffer, divider and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
      buck_tgt  <= '0;
      div       <= '0;
      ramp_pend <= 1'b0;
      bus_en    <= 1'b0;
      bus_addr  <= '0;
      bus_data  <= '0;
      buck_cur  <= '0;
      lockout   <= 1'b0;
      u_drop    <= 1'b0;
    end else begin
      state    <= state_next;
      bus_en   <= nxt_en;
      bus_addr <= nxt_addr;
      bus_data <= nxt_data;
      buck_cur <= cur_next;
      buck_tgt <= tgt_next;
      lockout  <= (state_next == ST_LOCKOUT);
      u_drop   <= u_valid && buf_valid && !drain;

      if (u_valid && (!buf_valid || drain)) begin
        buf_valid <= 1'b1;
        buf_addr  <= u_addr;
        buf_data  <= u_data;
      end else if (drain) begin
        buf_valid <= 1'b0;
      end

      // A blocked step stays pending with the divider frozen until it issues.
      if (state != ST_RAMP || ramp_wr) begin
        div       <= '0;
        ramp_pend <= 1'b0;
      end else if (ramp_fire) begin
        ramp_pend <= 1'b1;
      end else begin
        div <= div + DIV_ONE;
      end
    end
  end

endmodule

// File: tb/tb_conf_bus_sched.sv
// Self-checking bench for conf_bus_sched: vector table of UART writes plus
// hand-written ramp, fault, lockout, drop and reset sequences, with a write scoreboard.
module tb_conf_bus_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] u_data;
  logic [3:0] u_addr;
  logic       u_valid;
  logic       ocd_fault;
  logic [7:0] bus_data;
  logic [3:0] bus_addr;
  logic       bus_en;
  logic [7:0] buck_cur;
  logic       lockout;
  logic       u_drop;

  int tests  = 0;
  int failed = 0;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    bit         fwd;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[8];

  conf_bus_sched #(.RAMP_DIV(4)) dut (
    .clk(clk), .rst(rst), .u_data(u_data), .u_addr(u_addr), .u_valid(u_valid),
    .ocd_fault(ocd_fault), .bus_data(bus_data), .bus_addr(bus_addr), .bus_en(bus_en),
    .buck_cur(buck_cur), .lockout(lockout), .u_drop(u_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Advance one cycle and score any bus write against the expected queue.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (bus_en === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write", bus_addr, bus_data);
      end else begin
        e = sb.pop_front();
        check("bus_write", {20'd0, bus_addr, bus_data}, {20'd0, e.addr, e.data});
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic uart(input logic [3:0] a, input logic [7:0] d);
    u_addr  = a;
    u_data  = d;
    u_valid = 1'b1;
    tick();
    u_valid = 1'b0;
  endtask

  task automatic push(input logic [3:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    check(name, sb.size(), 0);
  endtask

  initial begin
    vecs[0] = '{4'd2,  8'h5A, 1'b1};
    vecs[1] = '{4'd0,  8'h00, 1'b1};
    vecs[2] = '{4'd3,  8'hFF, 1'b1};
    vecs[3] = '{4'd7,  8'h81, 1'b1};
    vecs[4] = '{4'd14, 8'h3C, 1'b1};
    vecs[5] = '{4'd1,  8'h55, 1'b1};
    vecs[6] = '{4'd15, 8'hA5, 1'b0};
    vecs[7] = '{4'd9,  8'h01, 1'b1};

    rst = 1'b1; u_data = 8'd0; u_addr = 4'd0; u_valid = 1'b0; ocd_fault = 1'b0;
    ticks(3);
    check("rst_bus_en", {31'd0, bus_en}, 32'd0);
    check("rst_bus", {20'd0, bus_addr, bus_data}, 32'd0);
    check("rst_buck_cur", {24'd0, buck_cur}, 32'd0);
    check("rst_flags", {30'd0, lockout, u_drop}, 32'd0);
    rst = 1'b0;
    tick();

    // UART forwarding: write appears exactly two edges after the strobe, one cycle wide.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].fwd) push(vecs[i].addr, vecs[i].data);
      uart(vecs[i].addr, vecs[i].data);
      check("lat_plus1", {31'd0, bus_en}, 32'd0);
      tick();
      check("lat_plus2", {31'd0, bus_en}, {31'd0, vecs[i].fwd});
      tick();
      check("single_pulse", {31'd0, bus_en}, 32'd0);
    end
    wait_drain("table_drain", 4);

    // Ramp up to 10, then immediate ramp-down to 3.
    for (int v = 1; v <= 10; v++) push(4'd4, 8'(v));
    uart(4'd4, 8'd10);
    wait_drain("ramp_up", 100);
    ticks(10);
    check("ramp_up_cur", {24'd0, buck_cur}, 32'd10);
    push(4'd4, 8'd3);
    uart(4'd4, 8'd3);
    wait_drain("ramp_down", 20);
    ticks(10);
    check("ramp_down_cur", {24'd0, buck_cur}, 32'd3);

    // Mid-ramp fault: two shutdown writes on consecutive cycles, then frozen.
    for (int v = 4; v <= 8; v++) push(4'd4, 8'(v));
    uart(4'd4, 8'd20);
    wait_drain("ramp_mid", 40);
    push(4'd1, 8'd0);
    push(4'd4, 8'd0);
    ocd_fault = 1'b1;
    tick();
    ocd_fault = 1'b0;
    check("fault_gap", {31'd0, bus_en}, 32'd0);
    tick();
    check("fault_pw", {27'd0, bus_en, bus_addr}, {27'd0, 1'b1, 4'd1});
    tick();
    check("fault_buck", {27'd0, bus_en, bus_addr}, {27'd0, 1'b1, 4'd4});
    check("fault_lockout", {31'd0, lockout}, 32'd1);
    ticks(30);
    check("locked_cur", {24'd0, buck_cur}, 32'd0);
    check("locked_flag", {31'd0, lockout}, 32'd1);

    // Lockout clear: ignored while fault active, accepted once it drops.
    uart(4'd4, 8'd5);
    ocd_fault = 1'b1;
    uart(4'd15, 8'd0);
    ticks(5);
    check("clr_ignored", {31'd0, lockout}, 32'd1);
    ocd_fault = 1'b0;
    for (int v = 1; v <= 5; v++) push(4'd4, 8'(v));
    uart(4'd15, 8'd0);
    ticks(2);
    check("clr_accepted", {31'd0, lockout}, 32'd0);
    wait_drain("ramp_restart", 60);
    ticks(8);
    check("restart_cur", {24'd0, buck_cur}, 32'd5);

    // Back-to-back UART strobes during the fault writes: second one dropped.
    push(4'd1, 8'd0);
    push(4'd4, 8'd0);
    ocd_fault = 1'b1;
    tick();
    ocd_fault = 1'b0;
    u_addr = 4'd2; u_data = 8'h11; u_valid = 1'b1;
    tick();
    u_addr = 4'd3; u_data = 8'h22;
    tick();
    u_valid = 1'b0;
    check("drop_pulse", {31'd0, u_drop}, 32'd1);
    push(4'd2, 8'h11);
    tick();
    check("drop_single", {31'd0, u_drop}, 32'd0);
    wait_drain("buffered_after_fault", 10);
    uart(4'd15, 8'd0);
    ticks(3);
    check("clr2", {31'd0, lockout}, 32'd0);

    // Reset during FAULT_PW with a UART write arriving: everything discarded.
    ocd_fault = 1'b1;
    tick();
    ocd_fault = 1'b0;
    u_addr = 4'd2; u_data = 8'h77; u_valid = 1'b1;
    rst = 1'b1;
    tick();
    u_valid = 1'b0;
    check("rst_mid_en", {31'd0, bus_en}, 32'd0);
    check("rst_mid_flags", {30'd0, lockout, u_drop}, 32'd0);
    check("rst_mid_cur", {24'd0, buck_cur}, 32'd0);
    rst = 1'b0;
    ticks(20);
    check("rst_mid_quiet", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
